// File: rtl/r8mbe_pp_accum_pkg.sv
// Shared constants, types and partial-product alignment helper for the
// radix-8 MBE partial-product accumulator.
package r8mbe_pkg;

   localparam int NUM_PP     = 8;
   localparam int PP_WIDTH   = 26;
   localparam int PP_SHIFT   = 3;
   localparam int PROD_WIDTH = 48;

   typedef logic [PP_WIDTH-1:0]   pp_t;
   typedef pp_t  [NUM_PP-1:0]     pp_array_t;
   typedef logic [PROD_WIDTH-1:0] prod_t;

   // k is the zero-based partial-product index, so P(k+1) gets weight 2^(3k).
   function automatic prod_t align_pp(pp_t pp, int k);
      prod_t ext;
      ext = {{(PROD_WIDTH-PP_WIDTH){pp[PP_WIDTH-1]}}, pp};
      return ext << (PP_SHIFT * k);
   endfunction

endpackage

// File: rtl/r8mbe_pp_accum_pipe_stage.sv
// Single valid/ready register slice with synchronous flush; ready is
// combinational from downstream ready (no skid buffer).
module r8mbe_pipe_stage #(
   parameter int WIDTH = 48
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             flush_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [WIDTH-1:0] in_data_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] out_data_o
);

   logic             valid_d, valid_q;
   logic [WIDTH-1:0] data_d,  data_q;

   // Flush blocks acceptance so nothing offered during a flush is captured.
   assign in_ready_o  = !flush_i && (!valid_q || out_ready_i);
   assign out_valid_o = valid_q;
   assign out_data_o  = data_q;

   always_comb begin
      // NOTE: defaults first so every path assigns every output -- no latch.
      valid_d = valid_q;
      data_d  = data_q;
      if (flush_i) begin
         valid_d = 1'b0;
      end else if (in_valid_i && in_ready_o) begin
         valid_d = 1'b1;
         data_d  = in_data_i;
      end else if (out_ready_i) begin
         valid_d = 1'b0;
      end
   end

   // NOTE: the data register is reset too, so product_o reads 0 out of reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         // NOTE: non-blocking assignments for all state so flops update together.
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

endmodule

// File: rtl/r8mbe_pp_accum.sv
// Two-stage pipelined accumulator: aligns and sums eight signed radix-8 MBE
// partial products into the 48-bit product of a 24x24 mantissa multiply.
module r8mbe_pp_accum
   import r8mbe_pkg::*;
(
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         flush_i,
   input  logic                         in_valid_i,
   output logic                         in_ready_o,
   input  logic [NUM_PP*PP_WIDTH-1:0]   pp_i,
   output logic                         out_valid_o,
   input  logic                         out_ready_i,
   output logic [PROD_WIDTH-1:0]        product_o
);

   pp_array_t                 pp;
   prod_t                     sum_lo, sum_hi;
   logic [2*PROD_WIDTH-1:0]   s1_data;
   logic                      s1_valid, s2_ready;
   prod_t                     s2_sum;

   assign pp = pp_i;

   // Lower and upper halves are summed separately to split the adder tree.
   always_comb begin
      sum_lo = '0;
      sum_hi = '0;
      for (int k = 0; k < NUM_PP/2; k++) begin
         sum_lo = sum_lo + align_pp(pp[k], k);
         sum_hi = sum_hi + align_pp(pp[k + NUM_PP/2], k + NUM_PP/2);
      end
   end

   r8mbe_pipe_stage #(.WIDTH(2*PROD_WIDTH)) u_stage1 (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .flush_i     (flush_i),
      .in_valid_i  (in_valid_i),
      .in_ready_o  (in_ready_o),
      .in_data_i   ({sum_hi, sum_lo}),
      .out_valid_o (s1_valid),
      .out_ready_i (s2_ready),
      .out_data_o  (s1_data)
   );

   assign s2_sum = s1_data[PROD_WIDTH-1:0] + s1_data[2*PROD_WIDTH-1:PROD_WIDTH];

   r8mbe_pipe_stage #(.WIDTH(PROD_WIDTH)) u_stage2 (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .flush_i     (flush_i),
      .in_valid_i  (s1_valid),
      .in_ready_o  (s2_ready),
      .in_data_i   (s2_sum),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .out_data_o  (product_o)
   );

endmodule

// File: tb/tb_r8mbe_pp_accum.sv
// Directed table, hand-written corner sequences and a random Booth-encoded
// scoreboard run for r8mbe_pp_accum.
module tb_r8mbe_pp_accum;
   import r8mbe_pkg::*;

   typedef struct {
      pp_array_t pp;
      prod_t     exp;
   } vec_t;

   logic      clk_i = 1'b0;
   logic      rst_ni = 1'b0;
   logic      flush_i = 1'b0;
   logic      in_valid_i = 1'b0;
   logic      in_ready_o;
   pp_array_t pp_i = '0;
   logic      out_valid_o;
   logic      out_ready_i = 1'b0;
   prod_t     product_o;

   int        total = 0;
   int        bad = 0;
   prod_t     exp_q [$];
   prod_t     held_prod;
   bit        hold_pend = 1'b0;
   vec_t      tbl [10];

   r8mbe_pp_accum dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .flush_i     (flush_i),
      .in_valid_i  (in_valid_i),
      .in_ready_o  (in_ready_o),
      .pp_i        (pp_i),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .product_o   (product_o)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic pp_array_t one_pp(input int k, input pp_t val);
      pp_array_t p;
      p = '0;
      p[k] = val;
      return p;
   endfunction

   // Radix-8 Booth digits of signed y, each times signed x.
   function automatic pp_array_t booth_pps(input logic signed [23:0] x, input logic [23:0] y);
      pp_array_t p;
      longint    prod;
      int        d;
      for (int k = 0; k < NUM_PP; k++) begin
         d = -4 * int'(y[3*k+2]) + 2 * int'(y[3*k+1]) + int'(y[3*k]);
         if (k > 0) d = d + int'(y[3*k-1]);
         prod = longint'(x) * longint'(d);
         p[k] = prod[PP_WIDTH-1:0];
      end
      return p;
   endfunction

   // One cycle: inputs applied after the edge, handshake sampled at negedge.
   task automatic drive(input pp_array_t pp, input prod_t exp, input logic v,
                        input logic ordy, input logic fl, output logic acc);
      pp_i        = pp;
      in_valid_i  = v;
      out_ready_i = ordy;
      flush_i     = fl;
      @(negedge clk_i);
      acc = v && in_ready_o;
      if (acc) exp_q.push_back(exp);
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle(input int n, input logic ordy);
      logic acc;
      for (int i = 0; i < n; i++) drive('0, '0, 1'b0, ordy, 1'b0, acc);
   endtask

   // Output monitor: in-order data compare and stall stability.
   always @(negedge clk_i) begin
      if (!rst_ni) begin
         exp_q.delete();
         hold_pend = 1'b0;
      end else begin
         if (hold_pend) begin
            check("stall_valid", out_valid_o, 1);
            check("stall_data", product_o, held_prod);
         end
         hold_pend = 1'b0;
         if (flush_i) begin
            exp_q.delete();
         end else if (out_valid_o && out_ready_i) begin
            check("out_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) check("out_data", product_o, exp_q.pop_front());
         end else if (out_valid_o) begin
            hold_pend = 1'b1;
            held_prod = product_o;
         end
      end
   end

   initial begin
      logic              acc;
      int                idx, n_acc;
      pp_array_t         tmp;
      logic signed [23:0] rx;
      logic [23:0]       ry;
      longint            e;

      tbl[0] = '{one_pp(0, 26'h0000001), 48'h000000000001};
      tbl[1] = '{one_pp(7, 26'h0000001), 48'h000000200000};
      tbl[2] = '{one_pp(0, 26'h3FFFFFF), 48'hFFFFFFFFFFFF};
      tmp = one_pp(7, 26'h3FFFFF0);
      tmp[0] = 26'h0000001;
      tbl[3] = '{tmp, 48'hFFFFFE000001};
      tbl[4] = '{booth_pps(24'sd3, 24'd5), 48'h00000000000F};
      tbl[5] = '{booth_pps(24'sd0, 24'h123456), 48'h000000000000};
      tbl[6] = '{one_pp(1, 26'h2000000), 48'hFFFFF0000000};
      for (int k = 0; k < NUM_PP; k++) tmp[k] = 26'h0000001;
      tbl[7] = '{tmp, 48'h000000249249};
      tbl[8] = '{one_pp(7, 26'h3FFFFFF), 48'hFFFFFFE00000};
      tbl[9] = '{one_pp(7, 26'h1FFFFFF), 48'h3FFFFFE00000};

      // Reset state
      repeat (2) @(posedge clk_i);
      #1;
      check("rst_out_valid", out_valid_o, 0);
      check("rst_product", product_o, 0);
      check("rst_in_ready", in_ready_o, 1);
      rst_ni = 1'b1;
      idle(2, 1'b1);

      // Single product latency
      drive(tbl[0].pp, tbl[0].exp, 1'b1, 1'b1, 1'b0, acc);
      check("lat_accept", acc, 1);
      check("lat_edge1_valid", out_valid_o, 0);
      idle(1, 1'b1);
      check("lat_edge2_valid", out_valid_o, 1);
      check("lat_edge2_data", product_o, 48'h000000000001);
      idle(3, 1'b1);

      // Table back-to-back at full throughput
      for (int i = 0; i < 10; i++) begin
         drive(tbl[i].pp, tbl[i].exp, 1'b1, 1'b1, 1'b0, acc);
         check("tbl_accept", acc, 1);
         if (i >= 2) check("tbl_stream_valid", out_valid_o, 1);
      end
      idle(4, 1'b1);
      check("tbl_drained", exp_q.size(), 0);

      // Backpressure: only two fit, then release
      idx = 0;
      n_acc = 0;
      for (int c = 0; c < 6; c++) begin
         drive(tbl[idx].pp, tbl[idx].exp, 1'b1, 1'b0, 1'b0, acc);
         if (acc) begin
            idx++;
            n_acc++;
         end
      end
      check("bp_accepted", n_acc, 2);
      check("bp_in_ready", in_ready_o, 0);
      check("bp_out_valid", out_valid_o, 1);
      check("bp_head_data", product_o, tbl[0].exp);
      drive(tbl[idx].pp, tbl[idx].exp, 1'b1, 1'b1, 1'b0, acc);
      check("bp_release_accept", acc, 1);
      idle(4, 1'b1);
      check("bp_drained", exp_q.size(), 0);

      // Flush with two in flight and an input offered
      drive(tbl[3].pp, tbl[3].exp, 1'b1, 1'b0, 1'b0, acc);
      check("fl_fill0", acc, 1);
      drive(tbl[4].pp, tbl[4].exp, 1'b1, 1'b0, 1'b0, acc);
      check("fl_fill1", acc, 1);
      drive(tbl[5].pp, tbl[5].exp, 1'b1, 1'b1, 1'b1, acc);
      check("fl_no_capture", acc, 0);
      check("fl_out_valid", out_valid_o, 0);
      idle(1, 1'b1);
      check("fl_still_empty", out_valid_o, 0);
      drive(tbl[9].pp, tbl[9].exp, 1'b1, 1'b1, 1'b0, acc);
      check("fl_post_accept", acc, 1);
      idle(1, 1'b1);
      check("fl_post_valid", out_valid_o, 1);
      check("fl_post_data", product_o, tbl[9].exp);
      idle(3, 1'b1);

      // Asynchronous reset mid-clock with two in flight
      drive(tbl[6].pp, tbl[6].exp, 1'b1, 1'b0, 1'b0, acc);
      drive(tbl[7].pp, tbl[7].exp, 1'b1, 1'b0, 1'b0, acc);
      in_valid_i = 1'b0;
      #2 rst_ni = 1'b0;
      #1;
      check("arst_out_valid", out_valid_o, 0);
      check("arst_product", product_o, 0);
      #2 rst_ni = 1'b1;
      @(posedge clk_i);
      #1;
      drive(tbl[8].pp, tbl[8].exp, 1'b1, 1'b1, 1'b0, acc);
      check("arst_post_accept", acc, 1);
      check("arst_edge1_valid", out_valid_o, 0);
      idle(1, 1'b1);
      check("arst_edge2_valid", out_valid_o, 1);
      check("arst_edge2_data", product_o, tbl[8].exp);
      idle(3, 1'b1);

      // Random Booth-encoded operands under random handshake and flush
      for (int c = 0; c < 3000; c++) begin
         rx = 24'($urandom);
         if (rx[23] && rx[22:0] == 23'd0) rx = '0;
         ry = 24'($urandom);
         e  = longint'(rx) * longint'($signed(ry));
         drive(booth_pps(rx, ry), e[PROD_WIDTH-1:0], $urandom_range(0, 3) != 0,
               $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0, acc);
      end
      idle(5, 1'b1);
      check("rand_drained", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
